sm83_irq_ctrl: RTL

Parametrised interrupt controller for the sm83 core. It detects rising edges on up to eight peripheral request lines and holds them in the IF register. It holds the IE enable register and implements the IME master enable, including the one-instruction EI delay. It arbitrates pending requests by fixed priority, presents a dispatch vector to the core's sequencer, and generates the HALT wake-up signal.

---
 rtl/sm83_irq_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sm83_irq_ctrl.sv
// sm83 interrupt controller: IF/IE registers with rising-edge capture,
// IME master enable with the one-instruction EI delay, fixed-priority
// arbitration, registered dispatch vector and HALT wake-up.
module sm83_irq_ctrl #(
  parameter int          N_IRQ     = 5,
  parameter logic [15:0] VEC_BASE  = 16'h0040,
  parameter int          VEC_SHIFT = 3,
  parameter logic [15:0] IF_ADDR   = 16'hFF0F,
  parameter logic [15:0] IE_ADDR   = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [15:0]      addr,
  input  logic             write,
  input  logic [7:0]       d_in,
  output logic [7:0]       rd_data,
  output logic             sel,
  input  logic             instr_done,
  input  logic             ei,
  input  logic             di,
  input  logic             reti,
  output logic             int_req,
  input  logic             int_ack,
  output logic [15:0]      vector,
  output logic             ime,
  output logic             wake
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARMED = 2'd1,
    ST_ON    = 2'd2
  } ime_state_t;

  ime_state_t       r_state;
  logic             r_ime;
  logic [N_IRQ-1:0] r_irq_q;
  logic [N_IRQ-1:0] r_if;
  logic [7:0]       r_ie;
  logic [15:0]      r_vector;

  logic             w_if_hit;
  logic             w_ie_hit;
  logic             w_if_wr;
  logic             w_ie_wr;
  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_pend;
  logic             w_any;
  logic [2:0]       w_win_idx;
  logic [N_IRQ-1:0] w_win_oh;
  logic [N_IRQ-1:0] w_if_nxt;
  logic [7:0]       w_if_rd;
  logic [15:0]      w_vec;

  assign w_if_hit = (addr == IF_ADDR);
  assign w_ie_hit = (addr == IE_ADDR);
  assign w_if_wr  = write & w_if_hit;
  assign w_ie_wr  = write & w_ie_hit;
  assign w_edge   = irq_in & ~r_irq_q;
  assign w_pend   = r_ie[N_IRQ-1:0] & r_if;
  assign w_any    = |w_pend;
  assign w_vec    = VEC_BASE + (16'(w_win_idx) << VEC_SHIFT);

  assign sel     = w_if_hit | w_ie_hit;
  assign wake    = w_any;
  assign int_req = r_ime & w_any;
  assign ime     = r_ime;
  assign vector  = r_vector;

  // Lowest pending index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    w_win_idx = 3'd0;
    w_win_oh  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_win_idx   = 3'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  // Next IF: CPU write or hold, clear the dispatched bit, then OR in new edges
  // so an edge is never lost to a same-cycle write or acknowledge.
  always_comb begin
    w_if_nxt = w_if_wr ? d_in[N_IRQ-1:0] : r_if;
    if (int_ack && w_any) begin
      w_if_nxt = w_if_nxt & ~w_win_oh;
    end
    w_if_nxt = w_if_nxt | w_edge;
  end

  // Register read mux; unimplemented IF bits and unmapped addresses read as 1.
  always_comb begin
    w_if_rd              = 8'hFF;
    w_if_rd[N_IRQ-1:0]   = r_if;
    rd_data              = 8'hFF;
    if (w_if_hit) begin
      rd_data = w_if_rd;
    end else if (w_ie_hit) begin
      rd_data = r_ie;
    end
  end

  // Request sampling, IF/IE registers and the dispatch vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_q  <= '0;
      r_if     <= '0;
      r_ie     <= 8'h00;
      r_vector <= 16'h0000;
    end else if (ce) begin
      r_irq_q <= irq_in;
      r_if    <= w_if_nxt;
      if (w_ie_wr) begin
        r_ie <= d_in;
      end
      if (int_ack) begin
        r_vector <= w_any ? w_vec : 16'h0000;
      end
    end
  end

  // IME state machine; acknowledge and DI override EI/RETI, RETI enables at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_OFF;
      r_ime   <= 1'b0;
    end else if (ce) begin
      if (int_ack || di) begin
        r_state <= ST_OFF;
        r_ime   <= 1'b0;
      end else if (reti) begin
        r_state <= ST_ON;
        r_ime   <= 1'b1;
      end else begin
        case (r_state)
          ST_OFF: begin
            if (ei) begin
              r_state <= ST_ARMED;
              r_ime   <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (instr_done && !ei) begin
              r_state <= ST_ON;
              r_ime   <= 1'b1;
            end
          end
          default: begin
            r_state <= r_state;
            r_ime   <= r_ime;
          end
        endcase
      end
    end
  end

endmodule
